// File: rtl/corner_collect_pkg.sv
// Shared definitions for the FAST corner collector: default field widths and FSM states.
package corner_collect_pkg;

  localparam int unsigned WDef  = 8;
  localparam int unsigned XWDef = 11;
  localparam int unsigned YWDef = 10;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StActive = 2'd1,
    StDone   = 2'd2
  } state_e;

endpackage

// File: rtl/corner_fifo.sv
// Synchronous first-word-fall-through FIFO; head is visible one cycle after its push.
module corner_fifo #(
  parameter int unsigned WIDTH = 29,
  parameter int unsigned DEPTH = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             full_o,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             empty, full, do_push, do_pop;

  // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
  always_comb begin
    empty   = (wr_q == rd_q);
    full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    do_push = push_i & ~full;
    do_pop  = pop_i & ~empty;
    wr_d    = wr_q;
    rd_d    = rd_q;
    if (do_push) wr_d = wr_q + (AW+1)'(1);
    if (do_pop)  rd_d = rd_q + (AW+1)'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end

  assign full_o  = full;
  assign valid_o = ~empty;
  assign data_o  = empty ? '0 : mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/corner_collect.sv
// Frame sequencer and corner collector behind the FAST mask: tracks coordinates aligned
// to mask results, rejects border corners and queues {score,y,x} words for a consumer.
module corner_collect
  import corner_collect_pkg::*;
#(
  parameter int unsigned W      = WDef,
  parameter int unsigned XW     = XWDef,
  parameter int unsigned YW     = YWDef,
  parameter int unsigned IMG_W  = 752,
  parameter int unsigned IMG_H  = 480,
  parameter int unsigned BORDER = 3,
  parameter int unsigned LAT    = 7,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned MAXC   = 1023,
  localparam int unsigned CW    = $clog2(MAXC + 1),
  localparam int unsigned DW    = W + YW + XW
) (
  input  logic          c,
  input  logic          rst_n,
  input  logic          sof,
  input  logic          dv,
  input  logic [7:0]    t_cfg,
  output logic [7:0]    t,
  input  logic          q,
  input  logic [W-1:0]  score,
  output logic          cq_valid,
  input  logic          cq_ready,
  output logic [DW-1:0] cq_data,
  output logic [CW-1:0] corner_count,
  output logic          overflow,
  output logic          frame_done
);

  state_e          state_q, state_d;
  logic [LAT-1:0]  dv_pipe_q, dv_pipe_d;
  logic            dva, dva_prev_q;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [7:0]      t_q, t_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            in_x, in_y, accept, push, fifo_full;

  // Delay dv by LAT so it lines up with the mask's q/score for the same pixel.
  always_comb begin
    dv_pipe_d    = dv_pipe_q << 1;
    dv_pipe_d[0] = dv;
  end
  assign dva = dv_pipe_q[LAT-1];

  always_comb begin
    in_x   = (32'(x_q) >= BORDER) && (32'(x_q) < IMG_W - BORDER);
    in_y   = (32'(y_q) >= BORDER) && (32'(y_q) < IMG_H - BORDER);
    accept = q & dva & ~sof & (state_q == StActive) & in_x & in_y;
    push   = accept & ~fifo_full & (32'(cnt_q) != MAXC);
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    t_d     = t_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;

    if (dva) begin
      x_d = x_q + XW'(1);
    end else if (dva_prev_q) begin
      x_d = '0;
      y_d = y_q + YW'(1);
    end

    if (push)            cnt_d = cnt_q + CW'(1);
    if (accept && !push) ovf_d = 1'b1;

    case (state_q)
      StIdle:   state_d = StIdle;
      StActive: if (32'(y_q) == IMG_H) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    // A new frame restarts everything except the queued corners.
    if (sof) begin
      t_d     = t_cfg;
      x_d     = '0;
      y_d     = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      state_d = StActive;
    end
  end

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      dv_pipe_q  <= '0;
      dva_prev_q <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      t_q        <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      dv_pipe_q  <= dv_pipe_d;
      dva_prev_q <= dva;
      x_q        <= x_d;
      y_q        <= y_d;
      t_q        <= t_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  corner_fifo #(
    .WIDTH(DW),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i  (c),
    .rst_ni (rst_n),
    .push_i (push),
    .data_i ({score, y_q, x_q}),
    .full_o (fifo_full),
    .pop_i  (cq_ready),
    .valid_o(cq_valid),
    .data_o (cq_data)
  );

  assign t            = t_q;
  assign corner_count = cnt_q;
  assign overflow     = ovf_q;
  assign frame_done   = (state_q == StDone);

endmodule

// File: tb/tb_corner_collect.sv
// Directed bench for corner_collect on a 16x8 frame; a second instance has MAXC=3.
module tb_corner_collect;

  localparam int unsigned LAT  = 7;
  localparam int unsigned IMGW = 16;
  localparam int unsigned IMGH = 8;
  localparam int unsigned DEP  = 8;

  logic        clk = 1'b0;
  logic        rst_n, sof, dv, q, q_src;
  logic [7:0]  t_cfg, score, s_src;
  logic        rdy, rdy_m;

  logic [7:0]  t, t_m;
  logic        cq_valid, cqv_m, ovf, ovf_m, fd, fd_m;
  logic [28:0] cq_data, cqd_m;
  logic [9:0]  cnt;
  logic [1:0]  cnt_m;

  logic [LAT-1:0] qp;
  logic [7:0]     sp [LAT];

  int          total, bad, fd_total;
  logic        cm_v [IMGH][IMGW];
  logic [7:0]  cm_s [IMGH][IMGW];
  logic [28:0] mq [$];

  always #5 clk = ~clk;

  corner_collect #(
    .IMG_W(IMGW), .IMG_H(IMGH), .BORDER(3), .LAT(LAT), .DEPTH(DEP), .MAXC(1023)
  ) dut (
    .c(clk), .rst_n(rst_n), .sof(sof), .dv(dv), .t_cfg(t_cfg), .t(t), .q(q), .score(score),
    .cq_valid(cq_valid), .cq_ready(rdy), .cq_data(cq_data), .corner_count(cnt),
    .overflow(ovf), .frame_done(fd)
  );

  corner_collect #(
    .IMG_W(IMGW), .IMG_H(IMGH), .BORDER(3), .LAT(LAT), .DEPTH(DEP), .MAXC(3)
  ) dutm (
    .c(clk), .rst_n(rst_n), .sof(sof), .dv(dv), .t_cfg(t_cfg), .t(t_m), .q(q), .score(score),
    .cq_valid(cqv_m), .cq_ready(rdy_m), .cq_data(cqd_m), .corner_count(cnt_m),
    .overflow(ovf_m), .frame_done(fd_m)
  );

  // Stand-in for the mask: q/score appear LAT cycles after their pixel's dv.
  always @(posedge clk) begin
    qp    <= {qp[LAT-2:0], q_src};
    sp[0] <= s_src;
    for (int i = 1; i < LAT; i++) sp[i] <= sp[i-1];
  end
  assign q     = qp[LAT-1];
  assign score = sp[LAT-1];

  always @(negedge clk) begin
    if (fd) fd_total++;
    if (cqv_m && rdy_m) mq.push_back(cqd_m);
  end

  function automatic logic [28:0] pk(input int s, input int y, input int x);
    return {8'(s), 10'(y), 11'(x)};
  endfunction

  task automatic clear_map();
    for (int y = 0; y < IMGH; y++)
      for (int x = 0; x < IMGW; x++) begin
        cm_v[y][x] = 1'b0;
        cm_s[y][x] = 8'h00;
      end
  endtask

  task automatic set_c(input int x, input int y, input int s);
    cm_v[y][x] = 1'b1;
    cm_s[y][x] = 8'(s);
  endtask

  task automatic pulse_sof();
    sof = 1'b1;
    @(negedge clk);
    sof = 1'b0;
  endtask

  task automatic drive_rows(input int n);
    for (int y = 0; y < n; y++) begin
      for (int x = 0; x < IMGW; x++) begin
        dv    = 1'b1;
        q_src = cm_v[y][x];
        s_src = cm_s[y][x];
        @(negedge clk);
      end
      dv    = 1'b0;
      q_src = 1'b0;
      s_src = 8'h00;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic pop_one();
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < DEP + 2 && cq_valid; i++) pop_one();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++; if (t !== 8'd0) begin bad++; $display("FAIL reset_t: got %0h want 0", t); end
    total++; if (cq_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", cq_valid); end
    total++; if (cq_data !== 29'd0) begin bad++; $display("FAIL reset_data: got %h want 0", cq_data); end
    total++; if (cnt !== 10'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", cnt); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    total++; if (fd !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", fd); end
    total++;
    if ({t_m, cqv_m, cnt_m, ovf_m, fd_m} !== 13'd0) begin
      bad++; $display("FAIL reset_m: got %h want 0", {t_m, cqv_m, cnt_m, ovf_m, fd_m});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_threshold();
    clear_map();
    t_cfg = 8'd20;
    pulse_sof();
    total++; if (t !== 8'd20) begin bad++; $display("FAIL thr_load: got %0d want 20", t); end
    t_cfg = 8'd40;
    drive_rows(4);
    total++; if (t !== 8'd20) begin bad++; $display("FAIL thr_mid: got %0d want 20", t); end
    repeat (LAT + 3) @(negedge clk);
    pulse_sof();
    total++; if (t !== 8'd40) begin bad++; $display("FAIL thr_next: got %0d want 40", t); end
  endtask

  task automatic test_single_corner();
    int base;
    clear_map();
    set_c(5, 4, 'h3c);
    base = fd_total;
    pulse_sof();
    drive_rows(IMGH);
    repeat (20) @(negedge clk);
    total++; if (fd_total - base != 1) begin bad++; $display("FAIL single_done: got %0d pulses want 1", fd_total - base); end
    total++; if (cq_valid !== 1'b1) begin bad++; $display("FAIL single_valid: got %b want 1", cq_valid); end
    total++; if (cq_data !== pk('h3c, 4, 5)) begin bad++; $display("FAIL single_data: got %h want %h", cq_data, pk('h3c, 4, 5)); end
    total++; if (cnt !== 10'd1) begin bad++; $display("FAIL single_count: got %0d want 1", cnt); end
    pop_one();
    total++; if (cq_valid !== 1'b0) begin bad++; $display("FAIL single_pop: got %b want 0", cq_valid); end
  endtask

  task automatic test_border();
    clear_map();
    set_c(2, 4, 1);
    set_c(13, 4, 2);
    set_c(5, 2, 3);
    set_c(5, 5, 4);
    set_c(3, 3, 'h55);
    set_c(12, 4, 'h66);
    pulse_sof();
    drive_rows(IMGH);
    repeat (20) @(negedge clk);
    total++; if (cnt !== 10'd2) begin bad++; $display("FAIL border_count: got %0d want 2", cnt); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL border_ovf: got %b want 0", ovf); end
    total++; if (cq_data !== pk('h55, 3, 3)) begin bad++; $display("FAIL border_first: got %h want %h", cq_data, pk('h55, 3, 3)); end
    pop_one();
    total++; if (cq_data !== pk('h66, 4, 12)) begin bad++; $display("FAIL border_second: got %h want %h", cq_data, pk('h66, 4, 12)); end
    pop_one();
    total++; if (cq_valid !== 1'b0) begin bad++; $display("FAIL border_empty: got %b want 0", cq_valid); end
  endtask

  task automatic test_fifo_full();
    clear_map();
    for (int i = 0; i < DEP + 2; i++) set_c(3 + i, 3, 'h10 + i);
    pulse_sof();
    drive_rows(IMGH);
    repeat (20) @(negedge clk);
    total++; if (cnt !== 10'(DEP)) begin bad++; $display("FAIL full_count: got %0d want %0d", cnt, DEP); end
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL full_ovf: got %b want 1", ovf); end
    for (int i = 0; i < DEP; i++) begin
      total++;
      if (cq_valid !== 1'b1 || cq_data !== pk('h10 + i, 3, 3 + i)) begin
        bad++; $display("FAIL full_order%0d: got v=%b %h want %h", i, cq_valid, cq_data, pk('h10 + i, 3, 3 + i));
      end
      pop_one();
    end
    total++; if (cq_valid !== 1'b0) begin bad++; $display("FAIL full_empty: got %b want 0", cq_valid); end
  endtask

  task automatic test_maxc();
    int base;
    clear_map();
    for (int i = 0; i < 5; i++) set_c(3 + i, 4, 'h20 + i);
    base = mq.size();
    pulse_sof();
    drive_rows(IMGH);
    repeat (20) @(negedge clk);
    total++; if (mq.size() - base != 3) begin bad++; $display("FAIL maxc_queued: got %0d want 3", mq.size() - base); end
    total++; if (cnt_m !== 2'd3) begin bad++; $display("FAIL maxc_count: got %0d want 3", cnt_m); end
    total++; if (ovf_m !== 1'b1) begin bad++; $display("FAIL maxc_ovf: got %b want 1", ovf_m); end
    for (int i = 0; i < 3 && base + i < mq.size(); i++) begin
      total++;
      if (mq[base + i] !== pk('h20 + i, 4, 3 + i)) begin
        bad++; $display("FAIL maxc_entry%0d: got %h want %h", i, mq[base + i], pk('h20 + i, 4, 3 + i));
      end
    end
    drain();
  endtask

  task automatic test_abort();
    int base;
    clear_map();
    set_c(5, 3, 'ha1);
    base = fd_total;
    pulse_sof();
    drive_rows(4);
    repeat (LAT + 3) @(negedge clk);
    total++; if (cnt !== 10'd1) begin bad++; $display("FAIL abort_pre: got %0d want 1", cnt); end
    clear_map();
    set_c(6, 4, 'hb2);
    pulse_sof();
    total++; if (cnt !== 10'd0) begin bad++; $display("FAIL abort_clear: got %0d want 0", cnt); end
    repeat (10) @(negedge clk);
    total++; if (fd_total != base) begin bad++; $display("FAIL abort_nodone: got %0d pulses want 0", fd_total - base); end
    drive_rows(IMGH);
    repeat (20) @(negedge clk);
    total++; if (fd_total - base != 1) begin bad++; $display("FAIL abort_done: got %0d pulses want 1", fd_total - base); end
    total++; if (cnt !== 10'd1) begin bad++; $display("FAIL abort_count: got %0d want 1", cnt); end
    total++; if (cq_data !== pk('ha1, 3, 5)) begin bad++; $display("FAIL abort_old: got %h want %h", cq_data, pk('ha1, 3, 5)); end
    pop_one();
    total++; if (cq_data !== pk('hb2, 4, 6)) begin bad++; $display("FAIL abort_new: got %h want %h", cq_data, pk('hb2, 4, 6)); end
    pop_one();
    total++; if (cq_valid !== 1'b0) begin bad++; $display("FAIL abort_empty: got %b want 0", cq_valid); end
  endtask

  task automatic test_reset_midframe();
    clear_map();
    for (int i = 0; i < DEP + 2; i++) set_c(3 + i, 3, 'h40 + i);
    t_cfg = 8'h55;
    pulse_sof();
    drive_rows(4);
    repeat (LAT + 3) @(negedge clk);
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL rst_pre_ovf: got %b want 1", ovf); end
    rst_n = 1'b0;
    #1;
    total++; if (t !== 8'd0) begin bad++; $display("FAIL rst_t: got %0h want 0", t); end
    total++; if (cq_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", cq_valid); end
    total++; if (cq_data !== 29'd0) begin bad++; $display("FAIL rst_data: got %h want 0", cq_data); end
    total++; if (cnt !== 10'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", cnt); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL rst_ovf: got %b want 0", ovf); end
    total++; if (fd !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", fd); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (cq_valid !== 1'b0) begin bad++; $display("FAIL rst_fifo_lost: got %b want 0", cq_valid); end
  endtask

  initial begin
    total = 0; bad = 0; fd_total = 0;
    rst_n = 1'b0; sof = 1'b0; dv = 1'b0; q_src = 1'b0; s_src = 8'h00;
    t_cfg = 8'h00; rdy = 1'b0; rdy_m = 1'b1;
    test_reset();
    test_threshold();
    test_single_corner();
    test_border();
    test_fifo_full();
    test_maxc();
    test_abort();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
